// File: rtl/svn_pkg.sv
// Shared definitions for the seven-segment scan controller: state encodings,
// display-off levels and a constant-width helper.
package svn_pkg;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_SHOW  = 2'd1,
    SCAN_BLANK = 2'd2
  } scan_state_t;

  // Anodes and decimal point are active-low, so "off" is a one on every bit.
  localparam logic AN_OFF = 1'b1;
  localparam logic DP_OFF = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/svn_scan_timer.sv
// Saturating up-counter shared by the dwell and blank phases; the caller
// selects the terminal value and clears it on every phase change.
module svn_scan_timer
  import svn_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != term)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/svn_scan_ctrl.sv
// Time-multiplexed anode scan for a common-anode seven-segment display with a
// one-deep pending frame buffer that commits only at frame boundaries.
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   SCAN_IDLE  | display dark, idx held at 0, waiting for en
//   SCAN_SHOW  | anode idx lit (if enabled) for TICK_DIV cycles
//   SCAN_BLANK | all anodes off for BLANK_CYC cycles
module svn_scan_ctrl
  import svn_pkg::*;
#(
  parameter int N_DIG     = 8,
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 4
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic               en,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [4*N_DIG-1:0] wr_data,
  input  logic [N_DIG-1:0]   wr_dp,
  input  logic [N_DIG-1:0]   wr_mask,
  output logic [3:0]         nib,
  output logic               dp,
  output logic [N_DIG-1:0]   AN,
  output logic               frame_done
);

  localparam int IDX_W   = clog2(N_DIG);
  localparam int DWELL_W = clog2(TICK_DIV);
  localparam int BLANK_W = clog2(BLANK_CYC + 1);
  localparam int CNT_W   = max3(DWELL_W, BLANK_W, 1);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIG - 1);

  scan_state_t      state, nxt_state;
  logic [IDX_W-1:0] idx, nxt_idx;

  logic [3:0]       sh_data  [N_DIG];
  logic [3:0]       nxt_data [N_DIG];
  logic [N_DIG-1:0] sh_dp, sh_mask, nxt_dp_sh, nxt_mask_sh;

  logic [4*N_DIG-1:0] pend_data;
  logic [N_DIG-1:0]   pend_dp, pend_mask;
  logic               pend_full, nxt_pend_full;

  logic             t_clr, t_inc, t_tc;
  logic [CNT_W-1:0] t_term;
  logic             adv, wrap, commit, accept;

  logic [N_DIG-1:0] an_d;
  logic [3:0]       nib_d;
  logic             dp_d;

  assign t_term = (state == SCAN_BLANK) ? BLANK_LAST : DWELL_LAST;

  svn_scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .clr       (t_clr),
    .inc       (t_inc),
    .term      (t_term),
    .tc        (t_tc)
  );

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    t_clr     = 1'b0;
    t_inc     = 1'b0;
    adv       = 1'b0;
    wrap      = 1'b0;
    if (!en) begin
      nxt_state = SCAN_IDLE;
      nxt_idx   = '0;
      t_clr     = 1'b1;
    end else begin
      case (state)
        SCAN_IDLE: begin
          nxt_state = SCAN_SHOW;
          nxt_idx   = '0;
          t_clr     = 1'b1;
        end
        SCAN_SHOW: begin
          if (t_tc) begin
            t_clr = 1'b1;
            if (BLANK_CYC == 0) adv = 1'b1;
            else nxt_state = SCAN_BLANK;
          end else begin
            t_inc = 1'b1;
          end
        end
        SCAN_BLANK: begin
          if (t_tc) begin
            t_clr = 1'b1;
            adv   = 1'b1;
          end else begin
            t_inc = 1'b1;
          end
        end
        default: begin
          nxt_state = SCAN_IDLE;
          nxt_idx   = '0;
          t_clr     = 1'b1;
        end
      endcase
    end
    if (adv) begin
      wrap      = (idx == IDX_LAST);
      nxt_state = SCAN_SHOW;
      nxt_idx   = wrap ? '0 : idx + 1'b1;
    end
  end

  // Commit and accept are mutually exclusive: accept needs an empty buffer,
  // commit a full one, so a write landing on a wrap waits for the next wrap.
  assign commit = pend_full & ((state == SCAN_IDLE) | wrap);
  assign accept = wr_valid & wr_ready;

  always_comb begin
    nxt_pend_full = pend_full;
    if (accept) nxt_pend_full = 1'b1;
    else if (commit) nxt_pend_full = 1'b0;
  end

  always_comb begin
    nxt_data    = sh_data;
    nxt_dp_sh   = sh_dp;
    nxt_mask_sh = sh_mask;
    if (commit) begin
      for (int i = 0; i < N_DIG; i++) nxt_data[i] = pend_data[4*i +: 4];
      nxt_dp_sh   = pend_dp;
      nxt_mask_sh = pend_mask;
    end
  end

  // Outputs are decoded from the next-state values so that the registered
  // outputs line up with the state register on the same edge.
  always_comb begin
    an_d  = {N_DIG{AN_OFF}};
    nib_d = '0;
    dp_d  = DP_OFF;
    if (nxt_state == SCAN_SHOW) begin
      an_d[nxt_idx] = ~nxt_mask_sh[nxt_idx];
      nib_d         = nxt_data[nxt_idx];
      dp_d          = ~nxt_dp_sh[nxt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      state      <= SCAN_IDLE;
      idx        <= '0;
      sh_data    <= '{default: '0};
      sh_dp      <= '0;
      sh_mask    <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_mask  <= '0;
      pend_full  <= 1'b0;
      wr_ready   <= 1'b1;
      AN         <= {N_DIG{AN_OFF}};
      nib        <= '0;
      dp         <= DP_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      idx        <= nxt_idx;
      sh_data    <= nxt_data;
      sh_dp      <= nxt_dp_sh;
      sh_mask    <= nxt_mask_sh;
      if (accept) begin
        pend_data <= wr_data;
        pend_dp   <= wr_dp;
        pend_mask <= wr_mask;
      end
      pend_full  <= nxt_pend_full;
      wr_ready   <= ~nxt_pend_full;
      AN         <= an_d;
      nib        <= nib_d;
      dp         <= dp_d;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_svn_scan_ctrl.sv
// Bench for svn_scan_ctrl (N_DIG=4, TICK_DIV=3, BLANK_CYC=1): stimulus pushes
// cycle-stamped expected display outputs, a monitor pops and compares them.
module tb_svn_scan_ctrl;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        en;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  wr_mask;
  logic [3:0]  nib;
  logic        dp;
  logic [3:0]  AN;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int c;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [3:0] nib;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t q[$];

  svn_scan_ctrl #(.N_DIG(4), .TICK_DIV(3), .BLANK_CYC(1)) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .en         (en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .wr_mask    (wr_mask),
    .nib        (nib),
    .dp         (dp),
    .AN         (AN),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 1000) begin
      step();
      guard++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_dark(input int t, input logic fd);
    exp_t e;
    e.cyc = t; e.an = 4'hF; e.nib = 4'h0; e.dp = 1'b1; e.fd = fd;
    q.push_back(e);
  endtask

  // One frame is 4 digits x (3 dwell + 1 blank); n limits how many cycles are pushed.
  task automatic expect_frame(input int start, input logic [15:0] data, input logic [3:0] dpv,
                              input logic [3:0] mask, input logic fd_first, input int n);
    exp_t e;
    logic [3:0] oh;
    int k;
    k = 0;
    for (int d = 0; d < 4; d++) begin
      for (int s = 0; s < 4; s++) begin
        if (k < n) begin
          if (s < 3) begin
            oh    = 4'b0001 << d;
            e.cyc = start + k;
            e.an  = mask[d] ? ~oh : 4'hF;
            e.nib = data[4*d +: 4];
            e.dp  = ~dpv[d];
            e.fd  = fd_first && (d == 0) && (s == 0);
            q.push_back(e);
          end else begin
            push_dark(start + k, 1'b0);
          end
        end
        k++;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missed_sample: cyc %0d never compared", e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      n_tests++;
      if ({AN, nib, dp, frame_done} !== {e.an, e.nib, e.dp, e.fd}) begin
        n_fail++;
        $display("FAIL scan_out cyc %0d: got AN=%b nib=%h dp=%b fd=%b, expected AN=%b nib=%h dp=%b fd=%b",
                 cyc, AN, nib, dp, frame_done, e.an, e.nib, e.dp, e.fd);
      end
    end
  end

  initial begin
    int guard;
    sys_rst_n = 1'b0;
    en        = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    wr_dp     = '0;
    wr_mask   = '0;
    repeat (3) step();
    sys_rst_n = 1'b1;
    step();

    // Reset / idle state
    chk("rst_an", 32'(AN), 32'hF);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_nib", 32'(nib), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h1);
    chk("rst_frame_done", 32'(frame_done), 32'h0);

    // Write in IDLE commits on the following edge
    wr_data = 16'h4321; wr_dp = 4'b0100; wr_mask = 4'hF; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("wr_ready_full_idle", 32'(wr_ready), 32'h0);
    step();
    chk("wr_ready_idle_commit", 32'(wr_ready), 32'h1);

    c  = cyc;
    en = 1'b1;
    expect_frame(c + 1,  16'h4321, 4'b0100, 4'hF, 1'b0, 16);
    expect_frame(c + 17, 16'hABCD, 4'b0000, 4'hF, 1'b1, 16);

    // Mid-frame write; a second request while full must be ignored
    wait_cyc(c + 6);
    wr_data = 16'hABCD; wr_dp = 4'b0000; wr_mask = 4'hF; wr_valid = 1'b1;
    step();
    wr_data = 16'h5555; wr_dp = 4'hF;
    chk("wr_ready_after_accept", 32'(wr_ready), 32'h0);
    wait_cyc(c + 10);
    wr_valid = 1'b0;
    chk("wr_ready_while_full", 32'(wr_ready), 32'h0);
    wait_cyc(c + 16);
    chk("wr_ready_before_wrap", 32'(wr_ready), 32'h0);
    step();
    chk("wr_ready_after_wrap", 32'(wr_ready), 32'h1);

    // Masked digits 0 and 2; frame spacing stays 16
    wait_cyc(c + 20);
    wr_data = 16'h8765; wr_dp = 4'b0001; wr_mask = 4'b1010; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    expect_frame(c + 33, 16'h8765, 4'b0001, 4'b1010, 1'b1, 16);
    expect_frame(c + 49, 16'h8765, 4'b0001, 4'b1010, 1'b1, 9);

    // en dropped during digit 2 dwell, then restart from digit 0
    wait_cyc(c + 57);
    en = 1'b0;
    push_dark(c + 58, 1'b0);
    push_dark(c + 59, 1'b0);
    step();
    step();
    en = 1'b1;
    expect_frame(c + 60, 16'h8765, 4'b0001, 4'b1010, 1'b0, 12);

    // Reset mid-BLANK with a pending write
    wait_cyc(c + 62);
    wr_data = 16'h9999; wr_dp = 4'hF; wr_mask = 4'hF; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("wr_ready_pending_before_rst", 32'(wr_ready), 32'h0);
    wait_cyc(c + 71);
    sys_rst_n = 1'b0;
    push_dark(c + 72, 1'b0);
    step();
    chk("wr_ready_after_rst", 32'(wr_ready), 32'h1);
    sys_rst_n = 1'b1;
    expect_frame(c + 73, 16'h0000, 4'b0000, 4'b0000, 1'b0, 16);
    expect_frame(c + 89, 16'h0000, 4'b0000, 4'b0000, 1'b1, 4);

    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      step();
      guard++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d expected samples left, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
